// File: rtl/proc_seq_pkg.sv
// Shared definitions for the processor instruction sequencer.
//   DATA_W        : instruction/data word width (format IIIXXXYYY)
//   OP_MVI        : opcode of the two-word move-immediate instruction
//   state_t       : sequencer FSM states
//   ERR_*         : err_code encodings
//   opcode()      : extracts the opcode field from an instruction word
package proc_seq_pkg;

  localparam int DATA_W = 9;
  localparam int OP_HI  = DATA_W - 1;
  localparam int OP_LO  = DATA_W - 3;

  localparam logic [2:0] OP_MVI = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FINISH,
    S_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_MVI     = 2'b10;

  function automatic logic [2:0] opcode(input logic [DATA_W-1:0] word);
    return word[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/proc_prog_ram.sv
// Program store: DEPTH x DATA_W register array, synchronous write,
// two asynchronous read ports (instruction word and the word after it).
//   clk              : write clock
//   we/waddr/wdata   : write port
//   raddr_a/rdata_a  : read port for the instruction about to be issued
//   raddr_b/rdata_b  : read port for the following word (mvi immediate)
module proc_prog_ram #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  // NOTE: storage arrays are deliberately left out of reset; clearing every
  // word would force a flop-per-bit reset network and the host reloads
  // the program before use anyway.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/proc_instr_sequencer.sv
// Initiator side of the processor Run/Done/DIN interface. Issues the words of
// a host-loaded program one instruction at a time and waits for Done.
//   Clock, Resetn        : clock, synchronous active-low reset
//   start, abort         : begin a run at pc=0 / return to IDLE at once
//   prog_we/addr/wdata   : program-store write port (only while not busy)
//   prog_len             : program length in words, sampled on start
//   Done                 : processor instruction-complete
//   DIN, Run             : instruction/immediate and issue pulse to processor
//   busy                 : high in ISSUE/WAIT
//   pc                   : address of the instruction in flight
//   instr_count          : instructions completed this run (saturating)
//   seq_done             : one-cycle pulse on entry to FINISH
//   error, err_code      : ERROR state flag and cause
module proc_instr_sequencer #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 9,
  parameter int TIMEOUT_W = 4
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              start,
  input  logic              abort,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_wdata,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              Done,
  output logic [DATA_W-1:0] DIN,
  output logic              Run,
  output logic              busy,
  output logic [ADDR_W:0]   pc,
  output logic [7:0]        instr_count,
  output logic              seq_done,
  output logic              error,
  output logic [1:0]        err_code
);

  import proc_seq_pkg::*;

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  // Last WAIT cycle count before giving up: 2**TIMEOUT_W-1 WAIT cycles total.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

  state_t                state;
  logic [ADDR_W:0]       len_r;
  logic [TIMEOUT_W-1:0]  tmo;
  logic                  cur_mvi;

  logic                  idle_ok;
  logic                  wr_en;
  logic                  launch;
  logic                  retire;
  logic [ADDR_W:0]       step;
  logic [ADDR_W:0]       pc_nxt;
  logic [ADDR_W:0]       pc_nxt_inc;
  logic [ADDR_W:0]       len_nxt;
  logic [ADDR_W-1:0]     raddr_a;
  logic [ADDR_W-1:0]     raddr_b;
  logic [DATA_W-1:0]     rd_a;
  logic [DATA_W-1:0]     rd_b;
  logic [DATA_W-1:0]     instr_word;
  logic                  instr_mvi;
  logic                  mvi_short;

  assign idle_ok = (state inside {S_IDLE, S_FINISH, S_ERROR});
  assign wr_en   = prog_we && idle_ok;
  assign launch  = idle_ok && start && !abort;
  assign retire  = (state == S_WAIT) && Done;
  assign step    = cur_mvi ? (ADDR_W + 1)'(2) : (ADDR_W + 1)'(1);

  // The program store is addressed by the pc that will be current after this
  // edge, so the word entering ISSUE is already available to be registered
  // onto DIN in the same edge that raises Run.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_nxt  = pc;
    len_nxt = len_r;
    if (launch) begin
      pc_nxt  = '0;
      len_nxt = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    end else if (retire) begin
      pc_nxt = pc + step;
    end
  end

  assign raddr_a    = pc_nxt[ADDR_W-1:0];
  assign raddr_b    = pc_nxt[ADDR_W-1:0] + ADDR_W'(1);
  assign pc_nxt_inc = pc_nxt + (ADDR_W + 1)'(1);

  // A write in the same cycle as start must be seen by the first issue.
  assign instr_word = (wr_en && (prog_addr == raddr_a)) ? prog_wdata : rd_a;
  assign instr_mvi  = (opcode(instr_word) == OP_MVI);
  // mvi whose immediate would lie beyond the program end.
  assign mvi_short  = instr_mvi && (pc_nxt_inc >= len_nxt);

  proc_prog_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (Clock),
    .we      (wr_en),
    .waddr   (prog_addr),
    .wdata   (prog_wdata),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state       <= S_IDLE;
      DIN         <= '0;
      Run         <= 1'b0;
      busy        <= 1'b0;
      pc          <= '0;
      instr_count <= '0;
      seq_done    <= 1'b0;
      error       <= 1'b0;
      err_code    <= ERR_NONE;
      len_r       <= '0;
      tmo         <= '0;
      cur_mvi     <= 1'b0;
    end else begin
      Run      <= 1'b0;
      seq_done <= 1'b0;
      if (abort) begin
        // pc and instr_count are kept for post-mortem inspection.
        state    <= S_IDLE;
        DIN      <= '0;
        busy     <= 1'b0;
        error    <= 1'b0;
        err_code <= ERR_NONE;
      end else begin
        case (state)
          S_IDLE, S_FINISH, S_ERROR: begin
            if (start) begin
              len_r       <= len_nxt;
              pc          <= '0;
              instr_count <= '0;
              error       <= 1'b0;
              err_code    <= ERR_NONE;
              if (len_nxt == '0) begin
                state    <= S_FINISH;
                seq_done <= 1'b1;
                busy     <= 1'b0;
                DIN      <= '0;
              end else begin
                state <= S_ISSUE;
                busy  <= 1'b1;
                DIN   <= instr_word;
                Run   <= !mvi_short;
              end
            end
          end

          S_ISSUE: begin
            if (mvi_short) begin
              state    <= S_ERROR;
              error    <= 1'b1;
              err_code <= ERR_MVI;
              busy     <= 1'b0;
              DIN      <= '0;
            end else begin
              state   <= S_WAIT;
              cur_mvi <= instr_mvi;
              DIN     <= instr_mvi ? rd_b : '0;
              tmo     <= '0;
            end
          end

          S_WAIT: begin
            if (Done) begin
              pc          <= pc_nxt;
              instr_count <= (instr_count == 8'hFF) ? instr_count : instr_count + 8'd1;
              if (pc_nxt >= len_r) begin
                state    <= S_FINISH;
                seq_done <= 1'b1;
                busy     <= 1'b0;
                DIN      <= '0;
              end else begin
                state <= S_ISSUE;
                DIN   <= instr_word;
                Run   <= !mvi_short;
              end
            end else if (tmo == TMO_LAST) begin
              state    <= S_ERROR;
              error    <= 1'b1;
              err_code <= ERR_TIMEOUT;
              busy     <= 1'b0;
              DIN      <= '0;
            end else begin
              tmo <= tmo + TIMEOUT_W'(1);
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
